// File: rtl/m_mem_ctrl.sv
// M-stage data-memory controller: turns load/store ops into one handshaked
// bus transaction at a time, stalls the pipeline while busy, and formats
// byte enables, replicated write data and extended load data.
module m_mem_ctrl #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic [1:0]  MemtoReg,
    input  logic [1:0]  storeOP,
    input  logic [2:0]  DextOP,
    input  logic [31:0] ALU_C,
    input  logic [31:0] GRF_RD2,
    output logic        stall_M,
    output logic        done_M,
    output logic [31:0] rdata_M,
    output logic        align_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

    // Abort fires on the edge that ends the TIMEOUT-th busy cycle
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    state_t          state;
    logic [TO_W-1:0] cnt;
    logic [1:0]      op_alo;
    logic [2:0]      op_dext;

    logic        is_store, is_load, access, misal, start;
    logic [3:0]  be_next;
    logic [31:0] wdata_next, ext_data;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign is_store = (storeOP != 2'b00);
    assign is_load  = (MemtoReg == 2'b01);
    assign access   = m_valid & (is_store | is_load);
    assign start    = (state == IDLE) & access & ~misal;

    // Stall covers the accepting IDLE cycle plus every bus-busy cycle
    assign stall_M   = ~reset & (start | (state == REQ) | (state == WAIT_R));
    assign align_err = ~reset & (state == IDLE) & access & misal;

    // Alignment check; a store decides the op even if MemtoReg also says load
    always_comb begin
        misal = 1'b0;
        if (is_store) begin
            case (storeOP)
                2'b01:   misal = (ALU_C[1:0] != 2'b00);
                2'b10:   misal = ALU_C[0];
                default: misal = 1'b0;
            endcase
        end else begin
            case (DextOP)
                3'd1, 3'd2: misal = 1'b0;
                3'd3, 3'd4: misal = ALU_C[0];
                default:    misal = (ALU_C[1:0] != 2'b00);
            endcase
        end
    end

    // Store lane formatting; loads read the whole word
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = 32'h0;
        case (storeOP)
            2'b01: wdata_next = GRF_RD2;
            2'b10: begin
                be_next    = ALU_C[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{GRF_RD2[15:0]}};
            end
            2'b11: begin
                be_next    = 4'b0001 << ALU_C[1:0];
                wdata_next = {4{GRF_RD2[7:0]}};
            end
            default: ;
        endcase
    end

    // Little-endian lane pick and extension of returned read data
    always_comb begin
        rd_byte  = bus_rdata[{op_alo, 3'b000} +: 8];
        rd_half  = bus_rdata[{op_alo[1], 4'b0000} +: 16];
        ext_data = bus_rdata;
        case (op_dext)
            3'd1:    ext_data = {24'h0, rd_byte};
            3'd2:    ext_data = {{24{rd_byte[7]}}, rd_byte};
            3'd3:    ext_data = {16'h0, rd_half};
            3'd4:    ext_data = {{16{rd_half[15]}}, rd_half};
            default: ext_data = bus_rdata;
        endcase
    end

    // Transaction FSM with registered bus signals and completion flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rdata_M   <= 32'h0;
            done_M    <= 1'b0;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_be    <= 4'h0;
            bus_wdata <= 32'h0;
            op_alo    <= 2'b00;
            op_dext   <= 3'd0;
        end else begin
            done_M  <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    bus_req   <= 1'b1;
                    bus_we    <= is_store;
                    bus_addr  <= {ALU_C[31:2], 2'b00};
                    bus_be    <= be_next;
                    bus_wdata <= wdata_next;
                    op_alo    <= ALU_C[1:0];
                    op_dext   <= DextOP;
                    cnt       <= '0;
                    state     <= REQ;
                end
                REQ: begin
                    if (bus_gnt && bus_we) begin
                        bus_req <= 1'b0;
                        done_M  <= 1'b1;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        bus_req <= 1'b0;
                        rdata_M <= 32'h0;
                        bus_err <= 1'b1;
                        done_M  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (bus_gnt) begin
                            bus_req <= 1'b0;
                            state   <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid) begin
                        rdata_M <= ext_data;
                        done_M  <= 1'b1;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        rdata_M <= 32'h0;
                        bus_err <= 1'b1;
                        done_M  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Directed bench for m_mem_ctrl: a transaction-level model predicts the
// outputs every cycle, and literal expectations pin the key scenarios.
module tb_m_mem_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset, m_valid;
    logic [1:0]  MemtoReg, storeOP;
    logic [2:0]  DextOP;
    logic [31:0] ALU_C, GRF_RD2;
    logic        stall_M, done_M, align_err, bus_err, bus_req, bus_we;
    logic [31:0] rdata_M, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid;

    int vectors = 0;
    int miscompares = 0;

    // Monitor captures written by the compare process
    int          stall_cnt, done_cnt;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we;

    // Model of the outstanding transaction
    logic        m_busy, m_req, m_fin, m_err;
    logic [31:0] m_rdata;
    int          m_age;
    logic [1:0]  t_st;
    logic [2:0]  t_dx;
    logic [31:0] t_addr, t_rd2;

    m_mem_ctrl #(.TO_W(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .MemtoReg(MemtoReg),
        .storeOP(storeOP), .DextOP(DextOP), .ALU_C(ALU_C), .GRF_RD2(GRF_RD2),
        .stall_M(stall_M), .done_M(done_M), .rdata_M(rdata_M),
        .align_err(align_err), .bus_err(bus_err), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic acc_now();
        return m_valid && (MemtoReg == 2'b01 || storeOP != 2'b00);
    endfunction

    function automatic logic al_ok(logic [1:0] st, logic [2:0] dx, logic [31:0] a);
        if (st == 2'd1) return (a % 4) == 0;
        if (st == 2'd2) return (a % 2) == 0;
        if (st == 2'd3) return 1'b1;
        if (dx == 3'd1 || dx == 3'd2) return 1'b1;
        if (dx == 3'd3 || dx == 3'd4) return (a % 2) == 0;
        return (a % 4) == 0;
    endfunction

    function automatic logic [3:0] exp_be(logic [1:0] st, logic [31:0] a);
        if (st == 2'd2) return 4'(4'h3 << (a & 32'd2));
        if (st == 2'd3) return 4'(4'h1 << (a & 32'd3));
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wd(logic [1:0] st, logic [31:0] d);
        if (st == 2'd2) return (d & 32'hFFFF) * 32'h0001_0001;
        if (st == 2'd3) return (d & 32'hFF) * 32'h0101_0101;
        return d;
    endfunction

    function automatic logic [31:0] exp_ext(logic [2:0] dx, logic [31:0] a, logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * (a % 4))) & 32'hFF;
        h = (d >> (16 * ((a / 2) % 2))) & 32'hFFFF;
        case (dx)
            3'd1:    return b;
            3'd2:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd3:    return h;
            3'd4:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            default: return d;
        endcase
    endfunction

    // Model: advances on each clock edge, cleared by reset at once
    initial begin
        m_busy = 0; m_req = 0; m_fin = 0; m_err = 0; m_rdata = 0; m_age = 0;
        t_st = 0; t_dx = 0; t_addr = 0; t_rd2 = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_busy = 0; m_req = 0; m_fin = 0; m_err = 0; m_rdata = 0;
            end else if (m_fin) begin
                m_fin = 0; m_err = 0;
            end else if (!m_busy) begin
                if (acc_now() && al_ok(storeOP, DextOP, ALU_C)) begin
                    m_busy = 1; m_req = 1; m_age = 0;
                    t_st = storeOP; t_dx = DextOP; t_addr = ALU_C; t_rd2 = GRF_RD2;
                end
            end else begin
                logic fin_now;
                fin_now = 0;
                if (m_req) begin
                    if (bus_gnt) begin
                        m_req = 0;
                        if (t_st != 0) fin_now = 1;
                    end
                end else if (bus_rvalid) begin
                    m_rdata = exp_ext(t_dx, t_addr, bus_rdata);
                    fin_now = 1;
                end
                if (!fin_now && m_age == TMO - 1) begin
                    m_req = 0; m_rdata = 0; m_err = 1; fin_now = 1;
                end
                m_age++;
                if (fin_now) begin m_busy = 0; m_fin = 1; end
            end
        end
    end

    // Compare process: every falling edge against the model
    initial begin
        forever begin
            logic idle, acc, al;
            @(negedge clk);
            idle = !m_busy && !m_fin;
            acc  = acc_now();
            al   = al_ok(storeOP, DextOP, ALU_C);
            chk("stall_M",   32'(stall_M),   32'(!reset && (m_busy || (idle && acc && al))));
            chk("align_err", 32'(align_err), 32'(!reset && idle && acc && !al));
            chk("bus_req",   32'(bus_req),   32'(m_req));
            chk("done_M",    32'(done_M),    32'(m_fin));
            chk("bus_err",   32'(bus_err),   32'(m_fin && m_err));
            chk("rdata_M",   rdata_M,        m_rdata);
            if (m_req) begin
                chk("bus_addr", bus_addr,    t_addr & 32'hFFFF_FFFC);
                chk("bus_we",   32'(bus_we), 32'(t_st != 0));
                if (t_st != 0) begin
                    chk("bus_be",    32'(bus_be), 32'(exp_be(t_st, t_addr)));
                    chk("bus_wdata", bus_wdata,   exp_wd(t_st, t_rd2));
                end
            end
            if (stall_M) stall_cnt++;
            if (done_M) done_cnt++;
            if (bus_req) begin
                cap_be = bus_be; cap_addr = bus_addr; cap_wdata = bus_wdata; cap_we = bus_we;
            end
        end
    end

    task automatic tick; @(posedge clk); #1; endtask
    task automatic peek; @(negedge clk); endtask

    task automatic idle_in;
        m_valid = 0; storeOP = 0; MemtoReg = 0;
    endtask

    task automatic drive(input logic [1:0] st, input logic [2:0] dx,
                         input logic [31:0] a, input logic [31:0] d);
        m_valid = 1; storeOP = st; MemtoReg = (st == 0) ? 2'b01 : 2'b00;
        DextOP = dx; ALU_C = a; GRF_RD2 = d;
    endtask

    // Full access; returns at the falling edge of the completion cycle
    task automatic do_op(input logic [1:0] st, input logic [2:0] dx, input logic [31:0] a,
                         input logic [31:0] d, input int gdly, input int rdly,
                         input logic [31:0] rdat, input logic early);
        stall_cnt = 0; done_cnt = 0;
        drive(st, dx, a, d);
        tick;
        repeat (gdly) tick;
        bus_gnt = 1;
        if (early) begin bus_rvalid = 1; bus_rdata = 32'h1111_1111; end
        tick;
        bus_gnt = 0; bus_rvalid = 0;
        if (st == 0) begin
            repeat (rdly) tick;
            bus_rvalid = 1; bus_rdata = rdat;
            tick;
            bus_rvalid = 0;
        end
        idle_in;
        peek;
    endtask

    initial begin
        reset = 1; idle_in; DextOP = 0; ALU_C = 0; GRF_RD2 = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
        stall_cnt = 0; done_cnt = 0;
        cap_be = 0; cap_addr = 0; cap_wdata = 0; cap_we = 0;
        repeat (2) tick;
        peek;
        chk("rst rdata_M", rdata_M, 32'h0);
        chk("rst stall_M", 32'(stall_M), 32'h0);
        chk("rst bus_req", 32'(bus_req), 32'h0);
        chk("rst done_M",  32'(done_M),  32'h0);
        tick; reset = 0; tick;

        // sw, grant two cycles late
        do_op(2'd1, 3'd0, 32'h1004, 32'hDEAD_BEEF, 2, 0, 0, 0);
        chk("sw done_M", 32'(done_M), 32'h1);
        tick;
        chk("sw be",     32'(cap_be), 32'hF);
        chk("sw addr",   cap_addr,    32'h1004);
        chk("sw wdata",  cap_wdata,   32'hDEAD_BEEF);
        chk("sw stalls", stall_cnt,   4);
        chk("sw dones",  done_cnt,    1);

        // sb, immediate grant
        do_op(2'd3, 3'd0, 32'h1003, 32'h0000_00A5, 0, 0, 0, 0);
        tick;
        chk("sb be",     32'(cap_be), 32'h8);
        chk("sb wdata",  cap_wdata,   32'hA5A5_A5A5);
        chk("sb we",     32'(cap_we), 32'h1);
        chk("sb stalls", stall_cnt,   2);

        // sh upper half
        do_op(2'd2, 3'd0, 32'h3002, 32'hCAFE_1234, 0, 0, 0, 0);
        tick;
        chk("sh be",    32'(cap_be), 32'hC);
        chk("sh wdata", cap_wdata,   32'h1234_1234);

        // loads
        do_op(2'd0, 3'd2, 32'h2001, 0, 0, 0, 32'h0000_8000, 0);
        chk("lb rdata", rdata_M, 32'hFFFF_FF80);
        tick;
        chk("lb stalls", stall_cnt, 3);
        chk("lb we", 32'(cap_we), 32'h0);
        do_op(2'd0, 3'd1, 32'h2001, 0, 0, 1, 32'h0000_8000, 0);
        chk("lbu rdata", rdata_M, 32'h0000_0080);
        tick;
        do_op(2'd0, 3'd4, 32'h2002, 0, 0, 0, 32'h8001_0000, 0);
        chk("lh rdata", rdata_M, 32'hFFFF_8001);
        tick;
        do_op(2'd0, 3'd3, 32'h2006, 0, 0, 0, 32'hBEEF_1234, 1);
        chk("lhu early rvalid", rdata_M, 32'h0000_BEEF);
        tick;
        do_op(2'd0, 3'd0, 32'h3000, 0, 1, 0, 32'h89AB_CDEF, 0);
        chk("lw rdata", rdata_M, 32'h89AB_CDEF);
        tick;

        // misaligned accesses stay idle
        drive(2'd0, 3'd4, 32'h2001, 0);
        peek;
        chk("lh mis align_err", 32'(align_err), 32'h1);
        chk("lh mis stall",     32'(stall_M),   32'h0);
        tick; peek;
        chk("lh mis bus_req",   32'(bus_req),   32'h0);
        tick;
        drive(2'd1, 3'd0, 32'h1002, 32'h5);
        peek;
        chk("sw mis align_err", 32'(align_err), 32'h1);
        tick; idle_in; tick;

        // timeout in REQ: grant never comes
        stall_cnt = 0;
        drive(2'd0, 3'd0, 32'h4000, 0);
        tick; idle_in;
        repeat (4) tick;
        peek;
        chk("tmo req done_M",  32'(done_M),  32'h1);
        chk("tmo req bus_err", 32'(bus_err), 32'h1);
        chk("tmo req rdata",   rdata_M,      32'h0);
        tick;
        chk("tmo req stalls",  stall_cnt,    5);

        // timeout in WAIT_R: rvalid never comes
        do_op(2'd0, 3'd0, 32'h3000, 0, 0, 0, 32'h7777_7777, 0);
        tick;
        drive(2'd0, 3'd0, 32'h4040, 0);
        tick; bus_gnt = 1; tick; bus_gnt = 0; idle_in;
        repeat (3) tick;
        peek;
        chk("tmo rd bus_err", 32'(bus_err), 32'h1);
        chk("tmo rd rdata",   rdata_M,      32'h0);
        tick;

        // reset while waiting for read data; late rvalid ignored
        do_op(2'd0, 3'd0, 32'h3000, 0, 0, 0, 32'h7777_7777, 0);
        tick;
        drive(2'd0, 3'd4, 32'h2002, 0);
        tick; bus_gnt = 1; tick; bus_gnt = 0;
        reset = 1; idle_in;
        peek;
        chk("rst mid bus_req", 32'(bus_req), 32'h0);
        chk("rst mid stall",   32'(stall_M), 32'h0);
        tick; reset = 0; tick;
        bus_rvalid = 1; bus_rdata = 32'h1234_5678; tick; bus_rvalid = 0;
        peek;
        chk("rst late rdata", rdata_M, 32'h0);
        chk("rst late done",  32'(done_M), 32'h0);
        tick;

        // recovery after reset
        do_op(2'd1, 3'd0, 32'h0008, 32'h0BAD_F00D, 0, 0, 0, 0);
        tick;
        chk("post rst wdata", cap_wdata, 32'h0BAD_F00D);
        repeat (2) tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
